sniffer_csr_slave: RTL and testbench



---
 rtl/sniffer_pkg.sv | 45 ++++
 rtl/csr_commit_fsm.sv | 65 ++++++
 rtl/sniffer_csr_slave.sv | 140 ++++++++++++++
 tb/tb_sniffer_csr_slave.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sniffer_pkg.sv
// Shared register map, control-bit positions and commit-FSM state type
// for the sniffer CSR slave.
package sniffer_pkg;

    // Word addresses, zero-extended to 32 bits so they compare cleanly
    // against any address width.
    localparam logic [31:0] ADDR_CTRL      = 32'd0;
    localparam logic [31:0] ADDR_STATUS    = 32'd1;
    localparam logic [31:0] ADDR_PORT_SH   = 32'd2;
    localparam logic [31:0] ADDR_IP_SH     = 32'd3;
    localparam logic [31:0] ADDR_MAC_SH_LO = 32'd4;
    localparam logic [31:0] ADDR_MAC_SH_HI = 32'd5;
    localparam logic [31:0] ADDR_PORT_LO   = 32'd8;
    localparam logic [31:0] ADDR_PORT_HI   = 32'd9;
    localparam logic [31:0] ADDR_IP_LO     = 32'd10;
    localparam logic [31:0] ADDR_IP_HI     = 32'd11;
    localparam logic [31:0] ADDR_MAC_LO    = 32'd12;
    localparam logic [31:0] ADDR_MAC_HI    = 32'd13;
    localparam logic [31:0] ADDR_URL_LO    = 32'd14;
    localparam logic [31:0] ADDR_URL_HI    = 32'd15;

    // CTRL bit positions; both live in byte 0.
    localparam int CTRL_ARM  = 0;
    localparam int CTRL_SNAP = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } commit_state_t;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/csr_commit_fsm.sv
// Commit sequencer: on ARM, spends one cycle committing the shadow
// patterns, then holds for SETTLE_CYCLES before reporting update_done.
module csr_commit_fsm
    import sniffer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    output logic capture,
    output logic cfg_load,
    output logic update_done,
    output logic busy
);

    commit_state_t state;
    logic [3:0]    settle_cnt;

    // The top copies shadows into cfg_* on the edge that leaves COMMIT,
    // so cfg_* and the cfg_load pulse become valid together.
    assign capture = (state == COMMIT);

    // State register, settle counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            cfg_load    <= 1'b0;
            update_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: state elements use non-blocking assignments so every
            // register updates from pre-edge values; cfg_load defaults low
            // here, which makes it a single-cycle pulse.
            cfg_load <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state       <= COMMIT;
                        update_done <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                COMMIT: begin
                    cfg_load   <= 1'b1;
                    settle_cnt <= 4'(SETTLE_CYCLES - 1);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    // ARM is deliberately not looked at here: no restart, no queue.
                    if (settle_cnt == 4'd0) begin
                        state       <= DONE;
                        update_done <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sniffer_csr_slave.sv
// Avalon-MM CSR slave: shadow pattern registers committed to the
// comparators via csr_commit_fsm, plus coherent hit-counter snapshots.
module sniffer_csr_slave
    import sniffer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ADDR_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    input  logic [63:0]       port_hits,
    input  logic [63:0]       ip_hits,
    input  logic [63:0]       mac_hits,
    input  logic [63:0]       url_hits,
    output logic [15:0]       cfg_port,
    output logic [31:0]       cfg_ip,
    output logic [47:0]       cfg_mac,
    output logic              cfg_load,
    output logic              update_done
);

    logic [31:0] addr;
    logic [15:0] port_sh;
    logic [31:0] ip_sh;
    logic [31:0] mac_sh_lo;
    logic [15:0] mac_sh_hi;
    logic [63:0] snap_port, snap_ip, snap_mac, snap_url;
    logic [31:0] port_next, ip_next, mac_lo_next, mac_hi_next;
    logic [31:0] rd_mux;
    logic        ctrl_wr, arm, snap, capture, busy;

    assign addr    = 32'(avs_address);
    assign ctrl_wr = avs_write && (addr == ADDR_CTRL) && avs_byteenable[0];
    assign arm     = ctrl_wr && avs_writedata[CTRL_ARM];
    assign snap    = ctrl_wr && avs_writedata[CTRL_SNAP];

    assign port_next   = byte_merge(32'(port_sh),   avs_writedata, avs_byteenable);
    assign ip_next     = byte_merge(ip_sh,          avs_writedata, avs_byteenable);
    assign mac_lo_next = byte_merge(mac_sh_lo,      avs_writedata, avs_byteenable);
    assign mac_hi_next = byte_merge(32'(mac_sh_hi), avs_writedata, avs_byteenable);

    csr_commit_fsm #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .capture     (capture),
        .cfg_load    (cfg_load),
        .update_done (update_done),
        .busy        (busy)
    );

    // Shadow registers: byte-granular writes, bits above width dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register here is a flop with a defined reset value;
            // nothing is RAM-mapped, so resetting all of them is cheap and safe.
            port_sh   <= '0;
            ip_sh     <= '0;
            mac_sh_lo <= '0;
            mac_sh_hi <= '0;
        end else if (avs_write) begin
            case (addr)
                ADDR_PORT_SH:   port_sh   <= port_next[15:0];
                ADDR_IP_SH:     ip_sh     <= ip_next;
                ADDR_MAC_SH_LO: mac_sh_lo <= mac_lo_next;
                ADDR_MAC_SH_HI: mac_sh_hi <= mac_hi_next[15:0];
                default: ;
            endcase
        end
    end

    // Active patterns: loaded from the shadows only while committing.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_port <= '0;
            cfg_ip   <= '0;
            cfg_mac  <= '0;
        end else if (capture) begin
            cfg_port <= port_sh;
            cfg_ip   <= ip_sh;
            cfg_mac  <= {mac_sh_hi, mac_sh_lo};
        end
    end

    // Snapshot all four counters on one edge so lo/hi halves are coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_port <= '0;
            snap_ip   <= '0;
            snap_mac  <= '0;
            snap_url  <= '0;
        end else if (snap) begin
            snap_port <= port_hits;
            snap_ip   <= ip_hits;
            snap_mac  <= mac_hits;
            snap_url  <= url_hits;
        end
    end

    // Read mux over current register values (pre-write on a same-cycle write).
    always_comb begin
        // NOTE: default assignment first keeps this purely combinational.
        rd_mux = '0;
        case (addr)
            ADDR_STATUS:    rd_mux = {30'd0, busy, update_done};
            ADDR_PORT_SH:   rd_mux = 32'(port_sh);
            ADDR_IP_SH:     rd_mux = ip_sh;
            ADDR_MAC_SH_LO: rd_mux = mac_sh_lo;
            ADDR_MAC_SH_HI: rd_mux = 32'(mac_sh_hi);
            ADDR_PORT_LO:   rd_mux = snap_port[31:0];
            ADDR_PORT_HI:   rd_mux = snap_port[63:32];
            ADDR_IP_LO:     rd_mux = snap_ip[31:0];
            ADDR_IP_HI:     rd_mux = snap_ip[63:32];
            ADDR_MAC_LO:    rd_mux = snap_mac[31:0];
            ADDR_MAC_HI:    rd_mux = snap_mac[63:32];
            ADDR_URL_LO:    rd_mux = snap_url[31:0];
            ADDR_URL_HI:    rd_mux = snap_url[63:32];
            default:        rd_mux = '0;
        endcase
    end

    // Fixed one-cycle read latency; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            avs_readdata      <= avs_read ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_sniffer_csr_slave.sv
// Directed bench for sniffer_csr_slave with hand-computed expectations.
module tb_sniffer_csr_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [63:0] port_hits, ip_hits, mac_hits, url_hits;
    logic [15:0] cfg_port;
    logic [31:0] cfg_ip;
    logic [47:0] cfg_mac;
    logic        cfg_load, update_done;

    int n_checks = 0;
    int n_pass   = 0;
    int loads;
    logic [31:0] d0, d1;

    always #5 clk = ~clk;

    sniffer_csr_slave #(.SETTLE_CYCLES(4), .ADDR_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .port_hits         (port_hits),
        .ip_hits           (ip_hits),
        .mac_hits          (mac_hits),
        .url_hits          (url_hits),
        .cfg_port          (cfg_port),
        .cfg_ip            (cfg_ip),
        .cfg_mac           (cfg_mac),
        .cfg_load          (cfg_load),
        .update_done       (update_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        tick();
        avs_write      = 1'b0;
        avs_byteenable = 4'h0;
    endtask

    task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string tag);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        check({tag, " valid"}, avs_readdatavalid, 1);
        check(tag, avs_readdata, exp);
        avs_read = 1'b0;
        tick();
        check({tag, " valid drop"}, avs_readdatavalid, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        port_hits = '0; ip_hits = '0; mac_hits = '0; url_hits = '0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state
        check("rst cfg_port", cfg_port, 0);
        check("rst cfg_mac", cfg_mac, 0);
        check("rst update_done", update_done, 0);
        check("rst cfg_load", cfg_load, 0);
        check("rst rdvalid", avs_readdatavalid, 0);
        read_check(4'd1, 32'h0, "rst status");

        // 2: program shadows and commit
        bus_write(4'd2, 32'h0000_0050, 4'hF);
        bus_write(4'd3, 32'hC0A8_0001, 4'hF);
        bus_write(4'd4, 32'h3344_5566, 4'hF);
        bus_write(4'd5, 32'h0000_1122, 4'hF);
        check("pre-arm cfg_port", cfg_port, 0);
        bus_write(4'd0, 32'h1, 4'hF);                      // edge T0
        check("T0 cfg_load", cfg_load, 0);
        check("T0 update_done", update_done, 0);
        tick();                                            // T1
        check("T1 cfg_load", cfg_load, 1);
        check("T1 cfg_port", cfg_port, 16'h0050);
        check("T1 cfg_ip", cfg_ip, 32'hC0A8_0001);
        check("T1 cfg_mac", cfg_mac, 48'h1122_3344_5566);
        tick(); tick(); tick();                            // T4
        check("T4 cfg_load", cfg_load, 0);
        check("T4 update_done", update_done, 0);
        tick();                                            // T5
        check("T5 update_done", update_done, 1);
        read_check(4'd1, 32'h1, "done status");

        // 3: byte enables, width truncation, RO/reserved addresses
        bus_write(4'd4, 32'h0000_0000, 4'hF);
        bus_write(4'd4, 32'hFFFF_FFFF, 4'b0011);
        read_check(4'd4, 32'h0000_FFFF, "mac_lo be0011");
        bus_write(4'd4, 32'hAABB_CCDD, 4'b1100);
        read_check(4'd4, 32'hAABB_FFFF, "mac_lo be1100");
        check("cfg_mac held", cfg_mac, 48'h1122_3344_5566);
        bus_write(4'd2, 32'hFFFF_1234, 4'hF);
        read_check(4'd2, 32'h0000_1234, "port_sh trunc");
        check("cfg_port held", cfg_port, 16'h0050);
        bus_write(4'd1, 32'hFFFF_FFFC, 4'hF);
        read_check(4'd1, 32'h1, "status ro");
        read_check(4'd6, 32'h0, "reserved");
        read_check(4'd0, 32'h0, "ctrl reads 0");

        // read and write of the same address in one cycle
        avs_address = 4'd2; avs_writedata = 32'h0000_ABCD; avs_byteenable = 4'hF;
        avs_write = 1'b1; avs_read = 1'b1;
        tick();
        avs_write = 1'b0; avs_read = 1'b0; avs_byteenable = 4'h0;
        check("rdw old value", avs_readdata, 32'h0000_1234);
        tick();
        read_check(4'd2, 32'h0000_ABCD, "rdw new value");

        // 4: coherent snapshot, back-to-back reads
        port_hits = 64'h0000_0001_FFFF_FFFF;
        ip_hits   = 64'hDEAD_BEEF_0123_4567;
        bus_write(4'd0, 32'h2, 4'hF);
        check("snap no arm", update_done, 1);
        port_hits = 64'h0000_0002_0000_0000;
        ip_hits   = 64'h0;
        avs_address = 4'd8; avs_read = 1'b1;
        tick();
        d0 = avs_readdata;
        check("b2b valid0", avs_readdatavalid, 1);
        avs_address = 4'd9;
        tick();
        d1 = avs_readdata;
        check("b2b valid1", avs_readdatavalid, 1);
        avs_read = 1'b0;
        tick();
        check("snap port lo", d0, 32'hFFFF_FFFF);
        check("snap port hi", d1, 32'h0000_0001);
        read_check(4'd10, 32'h0123_4567, "snap ip lo");
        read_check(4'd11, 32'hDEAD_BEEF, "snap ip hi");

        // 5: ARM during SETTLE is ignored
        loads = 0;
        bus_write(4'd0, 32'h1, 4'hF);                      // T0
        check("rearm ud drop", update_done, 0);
        tick();                                            // T1
        loads += int'(cfg_load);
        check("rearm cfg_port", cfg_port, 16'hABCD);
        bus_write(4'd0, 32'h1, 4'hF);                      // T2, in SETTLE
        loads += int'(cfg_load);
        tick(); loads += int'(cfg_load);                   // T3
        tick(); loads += int'(cfg_load);                   // T4
        check("rearm T4 ud", update_done, 0);
        tick(); loads += int'(cfg_load);                   // T5
        check("rearm T5 ud", update_done, 1);
        tick(); loads += int'(cfg_load);
        tick(); loads += int'(cfg_load);
        check("single cfg_load", loads, 1);

        // 6: reset during SETTLE with a read in flight
        bus_write(4'd2, 32'h0000_0BAD, 4'hF);
        bus_write(4'd0, 32'h1, 4'hF);                      // T0
        avs_address = 4'd1; avs_read = 1'b1;
        tick();                                            // T1
        check("settle status valid", avs_readdatavalid, 1);
        check("busy status", avs_readdata, 32'h2);
        rst = 1'b1;                                        // read still asserted
        tick();
        check("rst rdvalid drop", avs_readdatavalid, 0);
        check("rst rdata", avs_readdata, 0);
        check("rst2 update_done", update_done, 0);
        check("rst2 cfg_port", cfg_port, 0);
        check("rst2 cfg_ip", cfg_ip, 0);
        check("rst2 cfg_mac", cfg_mac, 0);
        check("rst2 cfg_load", cfg_load, 0);
        rst = 1'b0; avs_read = 1'b0;
        tick();
        read_check(4'd2, 32'h0, "rst2 port_sh");
        read_check(4'd8, 32'h0, "rst2 snapshot");

        // recovery: ARM and SNAP in one write
        url_hits = 64'h0123_4567_89AB_CDEF;
        bus_write(4'd2, 32'h0000_0443, 4'hF);
        bus_write(4'd0, 32'h3, 4'hF);                      // T0
        url_hits = 64'h0;
        tick();                                            // T1
        check("rec cfg_load", cfg_load, 1);
        check("rec cfg_port", cfg_port, 16'h0443);
        tick(); tick(); tick();                            // T4
        check("rec T4 ud", update_done, 0);
        tick();                                            // T5
        check("rec T5 ud", update_done, 1);
        read_check(4'd14, 32'h89AB_CDEF, "snap url lo");
        read_check(4'd15, 32'h0123_4567, "snap url hi");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
